unified_buffer_v2: RTL and testbench
====================================

Name: unified_buffer_v2

Overview:
Next-generation unified buffer: a parametrised single-clock simple-dual-port RAM holding activations and partial sums between host DMA and the systolic array.
- Adds per-lane write strobes, a valid/ready read interface with backpressure and an in-order output queue.
- Adds selectable read-during-write semantics and a hardware clear sweep.

Parameters:
DATA_W, 128, word width in bits; must be a multiple of LANE_W
LANE_W, 8, write-strobe granularity in bits; NL = DATA_W/LANE_W
DEPTH, 256, number of words; AW = clog2(DEPTH), minimum 1
OUT_REG, 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2; LAT = 1+OUT_REG
RDW_MODE, "WRITE_FIRST", same-address read/write in one cycle: "WRITE_FIRST" or "READ_FIRST"
INIT_FILE, "", hex file for $readmemh; empty means all words initialise to zero

Ports:
clk  input  1  clock, all logic on rising edge
rstb  input  1  synchronous active-high reset
wr_en  input  1  write request
wr_addr  input  AW  write address
wr_data  input  DATA_W  write data
wr_strb  input  NL  lane enables; bit i writes bits [i*LANE_W +: LANE_W]
wr_drop  output  1  registered pulse: previous-cycle write was discarded (clear in progress)
rd_req_valid  input  1  read request valid
rd_req_ready  output  1  read request accepted when valid & ready
rd_addr  input  AW  read address
rd_data_valid  output  1  head of output queue valid
rd_data_ready  input  1  consumer accepts head
rd_data  output  DATA_W  read data; 0 when rd_data_valid=0
clr_start  input  1  start clear sweep (ignored while busy)
clr_busy  output  1  clear sweep in progress

Behaviour:
- Reset (rstb=1 at an edge):
  - rd_data_valid, rd_req_ready, clr_busy and wr_drop go to 0; rd_data goes to 0.
  - Output queue, read pipeline, pending counter and clear counter are emptied.
  - Memory contents are not altered.
  - rd_req_ready rises in the cycle after rstb deasserts.
- Write:
  - On wr_en & !clr_busy, each lane with wr_strb[i]=1 is updated; other lanes are kept.
  - wr_strb=0 is a legal no-op.
- Read acceptance:
  - acc = rd_req_valid & rd_req_ready. The memory is read at the accepting edge.
  - Data enters the output queue LAT cycles after acceptance.
  - rd_data_valid is asserted no earlier than LAT cycles after acceptance.
  - Responses are strictly in request order.
- Pending counter P (registered, 0..LAT+1):
  - Counts requests in flight plus queued entries.
  - Update: P <= P + acc - (rd_data_valid & rd_data_ready).
  - rd_req_ready = !clr_busy & (P < LAT+1); no combinational path from rd_data_ready.
  - Output queue depth is LAT+1, so it never overflows. Throughput is 1 read per cycle while rd_data_ready=1.
- Backpressure: while rd_data_valid & !rd_data_ready, rd_data and the queue head are held stable.
- Read-during-write, same address, same cycle, write accepted:
  - WRITE_FIRST returns the strobe-merged new word.
  - READ_FIRST returns the old word.
  - Different addresses do not interact.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_start & !clr_busy. clr_busy=1 from the next cycle.
  - In SWEEP, a counter writes zero to address 0,1,...,DEPTH-1, one per cycle.
  - SWEEP -> IDLE after the DEPTH-1 write. clr_busy is high for exactly DEPTH cycles.
- During SWEEP:
  - rd_req_ready=0.
  - wr_en is ignored and wr_drop=1 in the following cycle.
  - Reads already accepted complete normally with pre-clear data.
  - Output handshakes continue.
- Simultaneous events:
  - clr_start with wr_en while IDLE: the write lands, then is overwritten by the sweep.
  - clr_start with an accepted read while IDLE: the read returns pre-clear data.
- Reset mid-sweep aborts the sweep. The memory stays partially cleared and is not defined further.
- Address wrap: none. Addresses >= DEPTH are illegal when DEPTH is not a power of 2; behaviour is undefined and an assertion flags it.

Test Plan:
1. Write a strobe merge, then read back. Stimulus: with DATA_W=128, write addr 5 all-ones, then write 0 with wr_strb=16'h00FF. Required response: reading addr 5 returns 128'hFFFF..FF_0000_0000_0000_0000 after LAT cycles.
2. Streaming reads. Stimulus: OUT_REG=1, rd_data_ready=1, read addresses 0..15 back-to-back. Required response: rd_req_ready stays 1, 16 contiguous valid beats, in order, first beat 2 cycles after first acceptance.
3. Backpressure. Stimulus: hold rd_data_ready=0 with requests continuously offered. Required response: exactly LAT+1 requests accepted, then rd_req_ready=0, rd_data stable. Releasing ready drains all entries in order with no loss or duplication.
4. Read-during-write. Stimulus: write 128'hA..A to addr 3 (old value 128'h5..5) and read addr 3 in the same cycle. Required response: returns A..A in WRITE_FIRST and 5..5 in READ_FIRST.
5. Clear sweep. Stimulus: with DEPTH=256, pulse clr_start, and during the sweep issue wr_en and a read request. Required response: clr_busy high for exactly 256 cycles, wr_drop pulses once, rd_req_ready=0 throughout. Afterwards every address reads 0.
6. Reset mid-operation. Stimulus: assert rstb with 2 reads queued and the sweep at address 100. Required response: next cycle rd_data_valid=0, rd_data=0, clr_busy=0, wr_drop=0, and no stale beat appears after reset release.

Source files
------------

// File: rtl/unified_buffer_v2_if.sv
// Signal bundle for unified_buffer_v2: strobed write port, read request/response streams, clear control.
interface unified_buffer_v2_if #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 256
);
  localparam int NL = DATA_W / LANE_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NL-1:0]     wr_strb;
  logic              wr_drop;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [AW-1:0]     rd_addr;
  logic              rd_data_valid;
  logic              rd_data_ready;
  logic [DATA_W-1:0] rd_data;
  logic              clr_start;
  logic              clr_busy;

  // Handshake rule for both read streams: a transfer occurs at a rising edge where valid & ready
  // are both 1; valid never depends on ready, and a presented response is held until taken.
  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_req_valid, rd_addr, rd_data_ready, clr_start,
    input  wr_drop, rd_req_ready, rd_data_valid, rd_data, clr_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_req_valid, rd_addr, rd_data_ready, clr_start,
    output wr_drop, rd_req_ready, rd_data_valid, rd_data, clr_busy
  );
endinterface

// File: rtl/unified_buffer_v2.sv
// Unified buffer: strobed simple-dual-port RAM with a credit-limited in-order read queue and a
// zeroing clear sweep.
module unified_buffer_v2 #(
  parameter int    DATA_W    = 128,
  parameter int    LANE_W    = 8,
  parameter int    DEPTH     = 256,
  parameter int    OUT_REG   = 0,
  parameter string RDW_MODE  = "WRITE_FIRST",
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rstb,
  unified_buffer_v2_if.slave bus,
  output logic               clr_state
);
  localparam int NL  = DATA_W / LANE_W;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT = 1 + OUT_REG;
  localparam int QD  = LAT + 1;
  localparam int CW  = $clog2(QD + 1);
  localparam int PW  = (QD > 2) ? 2 : 1;
  localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
  localparam bit POW2 = ((DEPTH & (DEPTH - 1)) == 0);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_t;

  clr_state_t        state, state_nxt;
  logic [AW-1:0]     clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] q [QD];
  logic [CW-1:0]     q_cnt, pend;
  logic [PW-1:0]     q_wp, q_rp;
  logic              ready_en, acc, pop, wr_ok, push;
  logic [DATA_W-1:0] push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign clr_state         = state;
  assign bus.clr_busy      = (state == SWEEP);
  // ready_en keeps the request port closed during reset and for the first edge after it.
  assign bus.rd_req_ready  = ready_en & ~bus.clr_busy & (pend < CW'(QD));
  assign acc               = bus.rd_req_valid & bus.rd_req_ready;
  assign pop               = bus.rd_data_valid & bus.rd_data_ready;
  assign wr_ok             = bus.wr_en & ~bus.clr_busy;
  assign bus.rd_data_valid = (q_cnt != '0);
  assign bus.rd_data       = bus.rd_data_valid ? q[q_rp] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_start) state_nxt = SWEEP;
      SWEEP:   if (clr_addr == AW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP) clr_addr <= (state_nxt == IDLE) ? '0 : clr_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb && state == SWEEP) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NL; i++)
        if (bus.wr_strb[i]) mem[bus.wr_addr][i*LANE_W +: LANE_W] <= bus.wr_data[i*LANE_W +: LANE_W];
    end
  end

  // Same-address bypass gives the strobe-merged new word; otherwise the array holds the old one.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (WRITE_FIRST && wr_ok && bus.wr_addr == bus.rd_addr) begin
      for (int i = 0; i < NL; i++)
        if (bus.wr_strb[i]) rd_word[i*LANE_W +: LANE_W] = bus.wr_data[i*LANE_W +: LANE_W];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              p_valid;
      logic [DATA_W-1:0] p_data;
      always_ff @(posedge clk) begin
        if (rstb) p_valid <= 1'b0;
        else      p_valid <= acc;
        if (acc) p_data <= rd_word;
      end
      assign push      = p_valid;
      assign push_data = p_data;
    end else begin : g_noreg
      assign push      = acc;
      assign push_data = rd_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) q[q_wp] <= push_data;
  end

  // pend covers the pipeline plus the queue, so the queue can never be pushed while full.
  always_ff @(posedge clk) begin
    if (rstb) begin
      q_cnt       <= '0;
      q_wp        <= '0;
      q_rp        <= '0;
      pend        <= '0;
      ready_en    <= 1'b0;
      bus.wr_drop <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      bus.wr_drop <= bus.wr_en & bus.clr_busy;
      if (push) q_wp <= ptr_inc(q_wp);
      if (pop)  q_rp <= ptr_inc(q_rp);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
      pend  <= pend + CW'(acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!POW2 && !rstb) begin
      assert (!bus.wr_en || int'(bus.wr_addr) < DEPTH);
      assert (!acc || int'(bus.rd_addr) < DEPTH);
    end
  end
endmodule

// File: tb/tb_unified_buffer_v2.sv
// Bench for unified_buffer_v2: directed vectors, expected beats queued at issue, checked by monitors.
`timescale 1ns/1ps
module tb_unified_buffer_v2;
  localparam int DW     = 128;
  localparam int LW     = 8;
  localparam int NL     = DW / LW;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  localparam int DEPTH2 = 16;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rstb;
  logic clr_state, clr_state2;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_q2 [$];
  logic [DW-1:0] mdl [DEPTH];
  bit   mon_en = 1'b0;
  bit   arm_first = 1'b0;
  bit   arm2 = 1'b0;
  int   first_beat_cyc = 0, last_beat_cyc = 0, beats = 0, first2 = 0;

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_buffer_v2_if #(.DATA_W(DW), .LANE_W(LW), .DEPTH(DEPTH))  bus ();
  unified_buffer_v2_if #(.DATA_W(DW), .LANE_W(LW), .DEPTH(DEPTH2)) bus2 ();

  unified_buffer_v2 #(.DATA_W(DW), .LANE_W(LW), .DEPTH(DEPTH), .OUT_REG(1),
                      .RDW_MODE("WRITE_FIRST"), .INIT_FILE("")) dut (
    .clk(clk), .rstb(rstb), .bus(bus), .clr_state(clr_state));

  unified_buffer_v2 #(.DATA_W(DW), .LANE_W(LW), .DEPTH(DEPTH2), .OUT_REG(0),
                      .RDW_MODE("READ_FIRST"), .INIT_FILE("")) dut_rf (
    .clk(clk), .rstb(rstb), .bus(bus2), .clr_state(clr_state2));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d tests run", n_tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {8{16'hA5C3 ^ 16'(i)}};
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_data_valid && bus.rd_data_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got beat %h with nothing expected", bus.rd_data);
        end else begin
          check("rd_data", bus.rd_data, exp_q.pop_front());
        end
        if (arm_first) begin
          first_beat_cyc = cyc;
          arm_first = 1'b0;
        end
        last_beat_cyc = cyc;
        beats++;
      end else if (!bus.rd_data_valid) begin
        check("rd_data_idle_zero", bus.rd_data, '0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && bus2.rd_data_valid && bus2.rd_data_ready) begin
      if (exp_q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rf_unexpected: got beat %h with nothing expected", bus2.rd_data);
      end else begin
        check("rf_rd_data", bus2.rd_data, exp_q2.pop_front());
      end
      if (arm2) begin
        first2 = cyc;
        arm2 = 1'b0;
      end
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] s);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    for (int l = 0; l < NL; l++) if (s[l]) mdl[a][l*LW +: LW] = d[l*LW +: LW];
  endtask

  task automatic rd_req(input logic [AW-1:0] a, input logic [DW-1:0] e, output int acc_cyc, output int stall);
    stall = 0;
    bus.rd_req_valid = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    while (!bus.rd_req_ready && stall < 500) begin
      stall++;
      @(negedge clk);
    end
    if (!bus.rd_req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_req_timeout: addr %0d never accepted", a);
    end else begin
      exp_q.push_back(e);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic rdw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] s,
                     input logic [DW-1:0] e);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
    bus.rd_req_valid = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    check_n("rdw_ready", bus.rd_req_ready, 1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_req_valid = 1'b0;
    for (int l = 0; l < NL; l++) if (s[l]) mdl[a][l*LW +: LW] = d[l*LW +: LW];
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_n(name, exp_q.size(), 0);
  endtask

  initial begin
    int acc0, a_cyc, st, stalls, accepted, ra, busy_cnt, drop_cnt, rdy_viol, beats0, acc2;
    logic first_busy;
    logic [DW-1:0] held;

    rstb = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.rd_req_valid = 1'b0; bus.rd_addr = '0; bus.rd_data_ready = 1'b1; bus.clr_start = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_strb = '0;
    bus2.rd_req_valid = 1'b0; bus2.rd_addr = '0; bus2.rd_data_ready = 1'b1; bus2.clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_n("rst_rd_data_valid", bus.rd_data_valid, 0);
    check("rst_rd_data", bus.rd_data, '0);
    check_n("rst_clr_busy", bus.clr_busy, 0);
    check_n("rst_wr_drop", bus.wr_drop, 0);
    check_n("rst_rd_req_ready", bus.rd_req_ready, 0);
    @(posedge clk); #1;
    rstb = 1'b0;
    @(negedge clk);
    check_n("ready_release_cycle", bus.rd_req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_n("ready_after_release", bus.rd_req_ready, 1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) wr(AW'(i), pat(i), '1);

    // strobe merge
    wr(8'd5, '1, '1);
    wr(8'd5, '0, 16'h00FF);
    rd_req(8'd5, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000, a_cyc, st);
    drain("strobe_drain");

    // streaming reads
    arm_first = 1'b1;
    beats0 = beats;
    stalls = 0;
    acc0 = 0;
    for (int i = 0; i < 16; i++) begin
      rd_req(AW'(i), mdl[i], a_cyc, st);
      if (i == 0) acc0 = a_cyc;
      stalls += st;
    end
    drain("stream_drain");
    check_n("stream_stalls", stalls, 0);
    check_n("stream_first_latency", first_beat_cyc - acc0, LAT);
    check_n("stream_contiguous", last_beat_cyc - first_beat_cyc, 15);
    check_n("stream_beats", beats - beats0, 16);

    // backpressure
    bus.rd_data_ready = 1'b0;
    accepted = 0;
    ra = 0;
    bus.rd_req_valid = 1'b1; bus.rd_addr = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rd_req_ready) begin
        exp_q.push_back(mdl[ra]);
        accepted++;
      end
      @(posedge clk); #1;
      ra = accepted;
      bus.rd_addr = AW'(ra);
    end
    check_n("bp_accepted", accepted, LAT + 1);
    @(negedge clk);
    check_n("bp_ready_low", bus.rd_req_ready, 0);
    check_n("bp_valid_high", bus.rd_data_valid, 1);
    held = bus.rd_data;
    check("bp_head", held, exp_q[0]);
    repeat (3) @(negedge clk);
    check("bp_stable", bus.rd_data, held);
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b0;
    bus.rd_data_ready = 1'b1;
    drain("bp_drain");

    // read-during-write, write-first instance
    wr(8'd3, {16{8'h55}}, '1);
    rdw(8'd3, {16{8'hAA}}, '1, {16{8'hAA}});
    rdw(8'd3, '0, 16'h000F, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000);
    drain("rdw_drain");

    // read-during-write, read-first instance (latency 1)
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'd3; bus2.wr_data = {16{8'h55}}; bus2.wr_strb = '1;
    @(posedge clk); #1;
    bus2.wr_data = {16{8'hAA}}; bus2.rd_req_valid = 1'b1; bus2.rd_addr = 4'd3;
    arm2 = 1'b1;
    @(negedge clk);
    check_n("rf_ready_0", bus2.rd_req_ready, 1);
    exp_q2.push_back({16{8'h55}});
    acc2 = cyc;
    @(posedge clk); #1;
    bus2.wr_en = 1'b0;
    @(negedge clk);
    check_n("rf_ready_1", bus2.rd_req_ready, 1);
    exp_q2.push_back({16{8'hAA}});
    @(posedge clk); #1;
    bus2.rd_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_n("rf_latency", first2 - acc2, 1);
    check_n("rf_drain", exp_q2.size(), 0);

    // clear sweep, with a write and a read in the start cycle
    bus.clr_start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = '1; bus.wr_strb = '1;
    bus.rd_req_valid = 1'b1; bus.rd_addr = 8'd2;
    @(negedge clk);
    check_n("clr_start_rd_ready", bus.rd_req_ready, 1);
    exp_q.push_back(mdl[2]);
    @(posedge clk); #1;
    bus.clr_start = 1'b0; bus.wr_en = 1'b0; bus.rd_req_valid = 1'b0;
    busy_cnt = 0; drop_cnt = 0; rdy_viol = 0; first_busy = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) first_busy = bus.clr_busy;
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_busy && bus.rd_req_ready) rdy_viol++;
      if (bus.wr_drop) drop_cnt++;
      @(posedge clk); #1;
      bus.wr_en = (k == 10); bus.wr_addr = 8'd9; bus.wr_data = '1; bus.wr_strb = '1;
      bus.rd_req_valid = (k >= 20 && k < 40); bus.rd_addr = 8'd4;
    end
    bus.wr_en = 1'b0; bus.rd_req_valid = 1'b0;
    check_n("clr_busy_next_cycle", first_busy, 1);
    check_n("clr_busy_cycles", busy_cnt, DEPTH);
    check_n("clr_wr_drop_pulses", drop_cnt, 1);
    check_n("clr_ready_while_busy", rdy_viol, 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    for (int i = 0; i < DEPTH; i++) rd_req(AW'(i), mdl[i], a_cyc, st);
    drain("clr_readback_drain");

    // reset mid-operation: two reads queued, sweep at address 100
    bus.rd_data_ready = 1'b0;
    bus.rd_req_valid = 1'b1; bus.rd_addr = 8'd0;
    @(posedge clk); #1;
    bus.rd_addr = 8'd1;
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b0;
    bus.clr_start = 1'b1;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_n("mid_valid_before_reset", bus.rd_data_valid, 1);
    check_n("mid_sweep_state", clr_state, 1);
    rstb = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 8'd11;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check_n("mid_rst_valid", bus.rd_data_valid, 0);
    check("mid_rst_rd_data", bus.rd_data, '0);
    check_n("mid_rst_clr_busy", bus.clr_busy, 0);
    check_n("mid_rst_wr_drop", bus.wr_drop, 0);
    check_n("mid_rst_state", clr_state, 0);
    @(posedge clk); #1;
    rstb = 1'b0;
    bus.rd_data_ready = 1'b1;
    beats0 = beats;
    repeat (10) @(posedge clk);
    #1;
    check_n("mid_no_stale_beats", beats - beats0, 0);
    check_n("mid_ready_back", bus.rd_req_ready, 1);
    check_n("final_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
